// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: IF state encoding,
// boot / exception vectors shared with CP0, and small address helpers.
package if_stage_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,   // presenting (or about to present) a fetch address
      ST_WAIT = 2'd1,   // address accepted, waiting for read data
      ST_HOLD = 2'd2    // one instruction buffered and offered to ID
   } if_state_t;

   localparam logic [31:0] IF_RESET_PC   = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VEC_BOOT  = 32'hBFC0_0380;
   localparam logic [31:0] EXC_VEC_NORM  = 32'h8000_0180;

   // A fetch address is legal only when word aligned.
   function automatic logic pc_aligned(input logic [31:0] pc);
      return (pc[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/if_stage_chk.sv
// Protocol checker for the instruction bus: read data may only come back
// while the fetch stage is actually waiting for it.
module if_stage_chk (
   input logic clk,
   input logic resetn,
   input logic in_wait,
   input logic inst_data_ok
);

   // data_ok outside the WAIT state is a slave protocol violation.
   a_data_ok_in_wait : assert property (@(posedge clk) disable iff (!resetn)
      inst_data_ok |-> in_wait);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the SRAM-like instruction
// bus, buffers one fetched instruction for ID, and handles branch delay
// slots and exception/eret flushes (including discarding a stale response).
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        if_id_stall,
   input  logic        exc_oc,
   input  logic [31:0] exc_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_adel
);

   if_state_t   state_r,      state_nxt_s;
   logic [31:0] pc_r,         pc_nxt_s;
   logic        drop,         drop_nxt_s;
   logic        br_pend,      br_pend_nxt_s;
   logic [31:0] br_tgt_q,     br_tgt_nxt_s;
   logic [31:0] req_addr_q,   req_addr_nxt_s;
   logic        inst_req_r,   inst_req_nxt_s;
   logic        if_valid_r,   if_valid_nxt_s;
   logic [31:0] if_pc_r,      if_pc_nxt_s;
   logic [31:0] if_inst_r,    if_inst_nxt_s;
   logic        if_adel_r,    if_adel_nxt_s;

   logic        fire_s;
   logic        br_acc_s;
   logic        addr_hs_s;
   logic [31:0] npc_s;

   assign inst_req  = inst_req_r;
   assign inst_addr = req_addr_q;
   assign if_valid  = if_valid_r;
   assign if_pc     = if_pc_r;
   assign if_inst   = if_inst_r;
   assign if_adel   = if_adel_r;

   // Next-state and next-output logic for the fetch FSM and its buffer.
   always_comb begin
      state_nxt_s    = state_r;
      pc_nxt_s       = pc_r;
      drop_nxt_s     = drop;
      br_pend_nxt_s  = br_pend;
      br_tgt_nxt_s   = br_tgt_q;
      req_addr_nxt_s = req_addr_q;
      inst_req_nxt_s = inst_req_r;
      if_valid_nxt_s = if_valid_r;
      if_pc_nxt_s    = if_pc_r;
      if_inst_nxt_s  = if_inst_r;
      if_adel_nxt_s  = if_adel_r;

      fire_s    = if_valid_r && !if_id_stall;
      br_acc_s  = br_taken && !if_id_stall && !exc_oc;
      addr_hs_s = inst_req_r && inst_addr_ok;
      // A branch accepted in the delay slot's own fire cycle wins over a pending one.
      if (br_acc_s) begin
         npc_s = br_target;
      end else if (br_pend) begin
         npc_s = br_tgt_q;
      end else begin
         npc_s = pc_r + 32'd4;
      end

      if (exc_oc) begin
         // Flush: redirect, forget any pending branch, kill what is in flight.
         pc_nxt_s      = exc_pc;
         br_pend_nxt_s = 1'b0;
         case (state_r)
            ST_REQ: begin
               if (inst_req_r) begin
                  // The outstanding address must still complete; its data is discarded.
                  drop_nxt_s = 1'b1;
                  if (addr_hs_s) begin
                     state_nxt_s    = ST_WAIT;
                     inst_req_nxt_s = 1'b0;
                  end else begin
                     state_nxt_s    = ST_REQ;
                  end
               end else begin
                  state_nxt_s = ST_REQ;
               end
            end
            ST_WAIT: begin
               if (inst_data_ok) begin
                  drop_nxt_s     = 1'b0;
                  state_nxt_s    = ST_REQ;
                  inst_req_nxt_s = pc_aligned(exc_pc);
                  req_addr_nxt_s = exc_pc;
               end else begin
                  drop_nxt_s     = 1'b1;
               end
            end
            ST_HOLD: begin
               state_nxt_s    = ST_REQ;
               if_valid_nxt_s = 1'b0;
               inst_req_nxt_s = pc_aligned(exc_pc);
               req_addr_nxt_s = exc_pc;
            end
            default: begin
               state_nxt_s    = ST_REQ;
               inst_req_nxt_s = 1'b0;
               if_valid_nxt_s = 1'b0;
            end
         endcase
      end else begin
         // Branch seen before its delay slot fires: remember the target.
         if (br_acc_s && !fire_s) begin
            br_pend_nxt_s = 1'b1;
            br_tgt_nxt_s  = br_target;
         end else begin
            br_tgt_nxt_s  = br_tgt_q;
         end
         case (state_r)
            ST_REQ: begin
               if (inst_req_r) begin
                  if (addr_hs_s) begin
                     state_nxt_s    = ST_WAIT;
                     inst_req_nxt_s = 1'b0;
                  end else begin
                     state_nxt_s    = ST_REQ;
                  end
               end else if (!pc_aligned(pc_r)) begin
                  // Misaligned PC: no bus cycle, deliver an AdEL marker instead.
                  state_nxt_s    = ST_HOLD;
                  if_valid_nxt_s = 1'b1;
                  if_pc_nxt_s    = pc_r;
                  if_inst_nxt_s  = 32'h0000_0000;
                  if_adel_nxt_s  = 1'b1;
               end else begin
                  inst_req_nxt_s = 1'b1;
                  req_addr_nxt_s = pc_r;
               end
            end
            ST_WAIT: begin
               if (inst_data_ok) begin
                  if (drop) begin
                     drop_nxt_s     = 1'b0;
                     state_nxt_s    = ST_REQ;
                     inst_req_nxt_s = pc_aligned(pc_r);
                     req_addr_nxt_s = pc_r;
                  end else begin
                     state_nxt_s    = ST_HOLD;
                     if_valid_nxt_s = 1'b1;
                     if_pc_nxt_s    = pc_r;
                     if_inst_nxt_s  = inst_rdata;
                     if_adel_nxt_s  = 1'b0;
                  end
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
            ST_HOLD: begin
               if (fire_s) begin
                  pc_nxt_s       = npc_s;
                  br_pend_nxt_s  = 1'b0;
                  state_nxt_s    = ST_REQ;
                  if_valid_nxt_s = 1'b0;
                  inst_req_nxt_s = pc_aligned(npc_s);
                  req_addr_nxt_s = npc_s;
               end else begin
                  state_nxt_s    = ST_HOLD;
               end
            end
            default: begin
               state_nxt_s    = ST_REQ;
               inst_req_nxt_s = 1'b0;
               if_valid_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // State, PC, bus request and output buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r    <= ST_REQ;
         pc_r       <= RESET_PC;
         drop       <= 1'b0;
         br_pend    <= 1'b0;
         br_tgt_q   <= 32'h0000_0000;
         req_addr_q <= RESET_PC;
         inst_req_r <= 1'b0;
         if_valid_r <= 1'b0;
         if_pc_r    <= 32'h0000_0000;
         if_inst_r  <= 32'h0000_0000;
         if_adel_r  <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         pc_r       <= pc_nxt_s;
         drop       <= drop_nxt_s;
         br_pend    <= br_pend_nxt_s;
         br_tgt_q   <= br_tgt_nxt_s;
         req_addr_q <= req_addr_nxt_s;
         inst_req_r <= inst_req_nxt_s;
         if_valid_r <= if_valid_nxt_s;
         if_pc_r    <= if_pc_nxt_s;
         if_inst_r  <= if_inst_nxt_s;
         if_adel_r  <= if_adel_nxt_s;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: an SRAM-like slave with random
// latencies, random ID stalls, branches and flushes; an abstract model
// predicts the PC sequence delivered to ID.
module tb_if_stage;
   import if_stage_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        if_id_stall;
   logic        exc_oc;
   logic [31:0] exc_pc;
   logic        br_taken;
   logic [31:0] br_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_adel;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          fires  = 0;
   int          phase  = 0;   // 0 directed, 1 random, 2 drain
   bit          go     = 1'b0;
   logic [31:0] expq[$];

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk(clk), .resetn(resetn), .if_id_stall(if_id_stall), .exc_oc(exc_oc),
      .exc_pc(exc_pc), .br_taken(br_taken), .br_target(br_target),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .if_valid(if_valid),
      .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel)
   );

   if_stage_chk chk (
      .clk(clk), .resetn(resetn), .in_wait(dut.state_r == ST_WAIT),
      .inst_data_ok(inst_data_ok)
   );

   // Memory image: the first word is fixed, the rest is a bijective hash.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h2408_0001;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver: bus slave, ID-side stimulus and the reference model.
   initial begin : driver
      bit          pend = 1'b0;
      int          cnt  = 0;
      logic [31:0] paddr = 32'h0;
      bit          m_br = 1'b0;
      logic [31:0] m_tgt = 32'h0;
      logic [31:0] cur;
      wait (go);
      forever begin
         @(negedge clk);
         if (inst_data_ok) pend = 1'b0;
         if (inst_req && inst_addr_ok) begin
            pend  = 1'b1;
            paddr = inst_addr;
            cnt   = (phase == 1) ? $urandom_range(0, 2) : 0;
         end
         @(posedge clk);
         #1;
         if (phase == 1) begin
            inst_addr_ok = ($urandom_range(0, 99) < 60);
            if_id_stall  = ($urandom_range(0, 99) < 30);
            exc_oc       = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 7))
               0:       exc_pc = 32'hBFC0_0382;
               1:       exc_pc = 32'hBFC0_0380;
               default: exc_pc = 32'hBFC0_0000 | ($urandom_range(0, 1023) << 2);
            endcase
            br_taken  = ($urandom_range(0, 99) < 10);
            br_target = 32'hBFC0_0000 | ($urandom_range(0, 1023) << 2);
         end else begin
            inst_addr_ok = 1'b1;
            if_id_stall  = 1'b0;
            exc_oc       = 1'b0;
            br_taken     = 1'b0;
         end
         if (pend && cnt == 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(paddr);
         end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = $urandom;
            if (pend) cnt--;
         end
         // Reference model: decide which PC ID should receive next.
         if (exc_oc) begin
            expq.delete();
            expq.push_back(exc_pc);
            m_br = 1'b0;
         end else begin
            if (br_taken && !if_id_stall) begin
               m_br  = 1'b1;
               m_tgt = br_target;
            end
            if (if_valid && !if_id_stall && expq.size() > 0) begin
               cur = expq[0];
               expq.push_back(m_br ? m_tgt : cur + 32'd4);
               m_br = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each delivery and checks bus rules.
   initial begin : monitor
      logic        p_valid = 1'b0, p_stall = 1'b0, p_exc = 1'b0;
      logic        p_req = 1'b0, p_aok = 1'b0;
      logic [31:0] p_pc = 32'h0, p_inst = 32'h0, p_addr = 32'h0;
      logic [31:0] e_pc;
      int          idle = 0;
      wait (go);
      forever begin
         @(negedge clk);
         if (p_valid && p_stall && !p_exc) begin
            check("stall_valid", {31'h0, if_valid}, 32'h1);
            check("stall_pc", if_pc, p_pc);
            check("stall_inst", if_inst, p_inst);
         end
         if (p_req && !p_aok) begin
            check("addr_hold_req", {31'h0, inst_req}, 32'h1);
            check("addr_hold", inst_addr, p_addr);
         end
         if (if_valid) check("no_req_in_hold", {31'h0, inst_req}, 32'h0);
         if (inst_req) check("req_aligned", {30'h0, inst_addr[1:0]}, 32'h0);
         if (if_valid && !if_id_stall && !exc_oc) begin
            fires++;
            idle = 0;
            if (expq.size() == 0) begin
               check("unexpected_delivery", if_pc, 32'hFFFF_FFFF);
            end else begin
               e_pc = expq.pop_front();
               check("deliver_pc", if_pc, e_pc);
               check("deliver_adel", {31'h0, if_adel}, {31'h0, (e_pc[1:0] != 2'b00)});
               check("deliver_inst", if_inst, (e_pc[1:0] != 2'b00) ? 32'h0 : mem_word(e_pc));
            end
         end else begin
            idle++;
            if (idle > 300) begin
               check("watchdog_idle_cycles", idle, 0);
               idle = 0;
            end
         end
         p_valid = if_valid; p_stall = if_id_stall; p_exc = exc_oc;
         p_pc = if_pc; p_inst = if_inst;
         p_req = inst_req; p_aok = inst_addr_ok; p_addr = inst_addr;
      end
   end

   // Main sequence: reset checks, directed first fetch, random run, drain.
   initial begin
      resetn = 1'b0; if_id_stall = 1'b0; exc_oc = 1'b0; exc_pc = 32'h0;
      br_taken = 1'b0; br_target = 32'h0; inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0; inst_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_inst_req", {31'h0, inst_req}, 32'h0);
      check("rst_if_valid", {31'h0, if_valid}, 32'h0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_inst", if_inst, 32'h0);
      check("rst_if_adel", {31'h0, if_adel}, 32'h0);
      expq.push_back(32'hBFC0_0000);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      go     = 1'b1;
      @(negedge clk);
      check("first_no_req", {31'h0, inst_req}, 32'h0);
      @(negedge clk);
      check("first_req", {31'h0, inst_req}, 32'h1);
      check("first_addr", inst_addr, 32'hBFC0_0000);
      @(negedge clk);
      @(negedge clk);
      check("first_valid_cycle3", {31'h0, if_valid}, 32'h1);
      check("first_pc", if_pc, 32'hBFC0_0000);
      @(negedge clk);
      check("second_req", {31'h0, inst_req}, 32'h1);
      check("second_addr", inst_addr, 32'hBFC0_0004);
      phase = 1;
      repeat (4000) @(posedge clk);
      phase = 2;
      repeat (200) @(posedge clk);
      @(negedge clk);
      check("progress", {31'h0, (fires > 100)}, 32'h1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
